// File: rtl/serial_pcpi_bridge_pkg.sv
// Shared types and default sizing for the serial-to-PCPI bridge.
package serial_pcpi_pkg;

    localparam int SEG_W_DEF   = 4;
    localparam int XLEN_DEF    = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/serial_pcpi_bridge_if.sv
// Bundles the segment streams, the PCPI co-processor bus and the status flags.
interface serial_pcpi_bridge_if
    import serial_pcpi_pkg::*;
#(
    parameter int SEG_W = SEG_W_DEF,
    parameter int XLEN  = XLEN_DEF
);
    logic             in_valid;
    logic [SEG_W-1:0] in_data;
    logic             in_ready;

    logic             out_valid;
    logic [SEG_W-1:0] out_data;
    logic             out_ready;

    logic             pcpi_valid;
    logic [XLEN-1:0]  pcpi_insn;
    logic [XLEN-1:0]  pcpi_rs1;
    logic [XLEN-1:0]  pcpi_rs2;
    logic             pcpi_ready;
    logic             pcpi_wr;
    logic             pcpi_wait;
    logic [XLEN-1:0]  pcpi_rd;

    logic             busy;
    logic             timeout_err;

    modport slave (
        input  in_valid, in_data, out_ready, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
        output in_ready, out_valid, out_data, pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output busy, timeout_err
    );

    modport master (
        output in_valid, in_data, out_ready, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
        input  in_ready, out_valid, out_data, pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  busy, timeout_err
    );
endinterface

// File: rtl/serial_pcpi_bridge_deser.sv
// Deserialiser: steers each accepted segment into insn/rs1/rs2, LS segment first.
// Accepts one segment per cycle while enabled; flags first and last segment of a transaction.
module serial_pcpi_deser
    import serial_pcpi_pkg::*;
#(
    parameter int SEG_W = SEG_W_DEF,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [SEG_W-1:0] dat_i,
    output logic [XLEN-1:0]  insn_o,
    output logic [XLEN-1:0]  rs1_o,
    output logic [XLEN-1:0]  rs2_o,
    output logic             first_o,
    output logic             last_o
);
    localparam int NSEG = XLEN / SEG_W;
    localparam int SCW  = (NSEG > 1) ? $clog2(NSEG) : 1;

    // The 0..3*NSEG-1 position is kept as (word, segment) to avoid a divider.
    logic [SCW-1:0]  seg_q;
    logic [1:0]      word_q;
    logic [XLEN-1:0] insn_q, rs1_q, rs2_q;
    logic            acc;
    logic            seg_last;

    assign acc      = en_i && vld_i;
    assign seg_last = (seg_q == SCW'(NSEG - 1));
    assign first_o  = acc && (seg_q == '0) && (word_q == 2'd0);
    assign last_o   = acc && seg_last && (word_q == 2'd2);
    assign insn_o   = insn_q;
    assign rs1_o    = rs1_q;
    assign rs2_o    = rs2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= '0;
            word_q <= 2'd0;
            insn_q <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else if (acc) begin
            case (word_q)
                2'd0:    insn_q[int'(seg_q)*SEG_W +: SEG_W] <= dat_i;
                2'd1:    rs1_q[int'(seg_q)*SEG_W +: SEG_W]  <= dat_i;
                default: rs2_q[int'(seg_q)*SEG_W +: SEG_W]  <= dat_i;
            endcase
            if (seg_last) begin
                seg_q  <= '0;
                word_q <= (word_q == 2'd2) ? 2'd0 : word_q + 2'd1;
            end else begin
                seg_q <= seg_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/serial_pcpi_bridge.sv
// Serial segments -> PCPI request; result returned serially when SERIAL_PCPI_READBACK_EN is defined.
// Issue starts the cycle after the last segment; in_ready low outside LOAD, result held under out_ready=0.
module serial_pcpi_bridge
    import serial_pcpi_pkg::*;
#(
    parameter int SEG_W   = SEG_W_DEF,
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_pcpi_bridge_if.slave  bus
);
    localparam int NSEG = XLEN / SEG_W;
    localparam int TCW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int OCW  = (NSEG > 1) ? $clog2(NSEG) : 1;

    generate
        if (XLEN % SEG_W != 0) begin : g_bad_width
            $error("serial_pcpi_bridge: XLEN must be a multiple of SEG_W");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic            terr_q, terr_d;
    logic            first_acc, last_acc;

    serial_pcpi_deser #(.SEG_W(SEG_W), .XLEN(XLEN)) u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == ST_LOAD),
        .vld_i   (bus.in_valid),
        .dat_i   (bus.in_data),
        .insn_o  (bus.pcpi_insn),
        .rs1_o   (bus.pcpi_rs1),
        .rs2_o   (bus.pcpi_rs2),
        .first_o (first_acc),
        .last_o  (last_acc)
    );

`ifdef SERIAL_PCPI_READBACK_EN
    logic [XLEN-1:0] res_q, res_d;
    logic [OCW-1:0]  oseg_q, oseg_d;
`endif

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
`ifdef SERIAL_PCPI_READBACK_EN
        res_d   = res_q;
        oseg_d  = oseg_q;
`endif
        if (first_acc) terr_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (last_acc) begin
                    state_d = ST_ISSUE;
                    tcnt_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (!bus.pcpi_wait) tcnt_d = tcnt_q + 1'b1;
                // A response in the expiry cycle still completes normally.
                if (bus.pcpi_ready) begin
`ifdef SERIAL_PCPI_READBACK_EN
                    if (bus.pcpi_wr) begin
                        res_d   = bus.pcpi_rd;
                        oseg_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
`else
                    state_d = ST_LOAD;
`endif
                end else if ((TIMEOUT != 0) && (tcnt_d == TCW'(TIMEOUT))) begin
                    state_d = ST_LOAD;
                    terr_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
`ifdef SERIAL_PCPI_READBACK_EN
                if (bus.out_ready) begin
                    if (oseg_q == OCW'(NSEG - 1)) begin
                        oseg_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        oseg_d = oseg_q + 1'b1;
                    end
                end
`else
                state_d = ST_LOAD;
`endif
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            tcnt_q  <= '0;
            terr_q  <= 1'b0;
`ifdef SERIAL_PCPI_READBACK_EN
            res_q   <= '0;
            oseg_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            terr_q  <= terr_d;
`ifdef SERIAL_PCPI_READBACK_EN
            res_q   <= res_d;
            oseg_q  <= oseg_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == ST_LOAD);
    assign bus.pcpi_valid  = (state_q == ST_ISSUE);
    assign bus.busy        = (state_q != ST_LOAD);
    assign bus.timeout_err = terr_q;

`ifdef SERIAL_PCPI_READBACK_EN
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_data  = res_q[int'(oseg_q)*SEG_W +: SEG_W];
`else
    logic unused_rb;
    assign unused_rb     = ^{bus.pcpi_wr, bus.pcpi_rd, bus.out_ready};
    assign bus.out_valid = 1'b0;
    assign bus.out_data  = '0;
`endif
endmodule

// File: tb/tb_serial_pcpi_bridge.sv
// Table-driven bench for serial_pcpi_bridge (SEG_W=4, XLEN=32, TIMEOUT=8) with operand/result scoreboards.
module tb_serial_pcpi_bridge;
    localparam int SEG_W = 4;
    localparam int XLEN  = 32;
    localparam int TMO   = 8;
    localparam int NSEG  = XLEN / SEG_W;

    typedef struct {
        logic [31:0] insn, rs1, rs2, rd;
        bit          wr;
        int          delay;
        bit          wt;
        bit          stall;
        bit          tmo;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   prev_tmo = 1'b0;
    vec_t vecs[6];
    logic [95:0] sb_q[$];
    logic [3:0]  out_q[$];

    serial_pcpi_bridge_if #(.SEG_W(SEG_W), .XLEN(XLEN)) bus ();

    serial_pcpi_bridge #(.SEG_W(SEG_W), .XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_txn(input vec_t v, input int nseg);
        logic [31:0] w;
        logic [95:0] exp;
        logic        pv_before;
        pv_before = 1'b0;
        sb_q.push_back({v.insn, v.rs1, v.rs2});
        if (prev_tmo) chk("terr_sticky", {31'd0, bus.timeout_err}, 32'd1);
        chk("in_ready_load", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < nseg; i++) begin
            w = (i < NSEG) ? v.insn : (i < 2*NSEG) ? v.rs1 : v.rs2;
            bus.in_valid = 1'b1;
            bus.in_data  = w[4*(i%NSEG) +: 4];
            if (i == 3*NSEG-1) begin
                #1;
                pv_before = bus.pcpi_valid;
            end
            tick();
            if (i == 0) chk("terr_clear", {31'd0, bus.timeout_err}, 32'd0);
        end
        bus.in_valid = 1'b0;
        prev_tmo = 1'b0;
        #1;
        if (nseg == 3*NSEG) begin
            chk("pv_rise", {30'd0, pv_before, bus.pcpi_valid}, 32'd1);
            exp = sb_q.pop_front();
            chk("pcpi_insn", bus.pcpi_insn, exp[95:64]);
            chk("pcpi_rs1",  bus.pcpi_rs1,  exp[63:32]);
            chk("pcpi_rs2",  bus.pcpi_rs2,  exp[31:0]);
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic respond(input vec_t v);
        bit hold_ok;
        int got, stalled;
        hold_ok = 1'b1;
        for (int c = 0; c < v.delay; c++) begin
            bus.pcpi_wait = v.wt;
            #1;
            if (!bus.pcpi_valid) hold_ok = 1'b0;
            tick();
        end
        if (v.tmo) begin
            bus.pcpi_wait = 1'b0;
            #1;
            chk("pv_held",  {31'd0, hold_ok}, 32'd1);
            chk("tmo_pv",   {31'd0, bus.pcpi_valid}, 32'd0);
            chk("tmo_err",  {31'd0, bus.timeout_err}, 32'd1);
            chk("tmo_busy", {31'd0, bus.busy}, 32'd0);
            prev_tmo = 1'b1;
            return;
        end
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = v.wr;
        bus.pcpi_rd    = v.rd;
        bus.pcpi_wait  = 1'b0;
        #1;
        if (!bus.pcpi_valid) hold_ok = 1'b0;
        chk("pv_held", {31'd0, hold_ok}, 32'd1);
        tick();
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        #1;
        chk("pv_drop", {31'd0, bus.pcpi_valid}, 32'd0);
        chk("no_terr", {31'd0, bus.timeout_err}, 32'd0);
`ifdef SERIAL_PCPI_READBACK_EN
        if (v.wr) begin
            for (int k = 0; k < NSEG; k++) out_q.push_back(v.rd[4*k +: 4]);
            got = 0;
            stalled = 0;
            for (int cy = 0; cy < 40 && out_q.size() > 0; cy++) begin
                bus.out_ready = !(v.stall && got == 3 && stalled < 3);
                #1;
                if (bus.out_valid) begin
                    if (!bus.out_ready) begin
                        chk("stall_hold", {28'd0, bus.out_data}, {28'd0, out_q[0]});
                        stalled++;
                    end else begin
                        chk("out_data", {28'd0, bus.out_data}, {28'd0, out_q.pop_front()});
                        got++;
                    end
                end
                tick();
            end
            chk("drain_left", out_q.size(), 32'd0);
            out_q.delete();
            bus.out_ready = 1'b0;
            #1;
            chk("drain_done", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
            return;
        end
`endif
        chk("back_to_load", {31'd0, bus.in_ready}, 32'd1);
        chk("out_idle", {27'd0, bus.out_valid, bus.out_data}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{insn: 32'h0200_000B, rs1: 32'h5, rs2: 32'h7, rd: 32'h1234_5678,
                    wr: 1, delay: 0, wt: 0, stall: 0, tmo: 0};
        vecs[1] = '{insn: 32'hDEAD_BEEF, rs1: 32'hFFFF_FFFF, rs2: 32'h0, rd: 32'hA5A5_F00F,
                    wr: 1, delay: 3, wt: 0, stall: 1, tmo: 0};
        vecs[2] = '{insn: 32'h1357_9BDF, rs1: 32'h2468_ACE0, rs2: 32'h0F0F_0F0F, rd: 32'h0,
                    wr: 0, delay: 20, wt: 1, stall: 0, tmo: 0};
        vecs[3] = '{insn: 32'h0000_0033, rs1: 32'h8000_0000, rs2: 32'h1, rd: 32'hCAFE_F00D,
                    wr: 1, delay: TMO-1, wt: 0, stall: 0, tmo: 0};
        vecs[4] = '{insn: 32'h0000_000B, rs1: 32'h1111_1111, rs2: 32'h2222_2222, rd: 32'h0,
                    wr: 1, delay: TMO, wt: 0, stall: 0, tmo: 1};
        vecs[5] = '{insn: 32'h8765_4321, rs1: 32'h0, rs2: 32'hFFFF_FFFF, rd: 32'h0F1E_2D3C,
                    wr: 1, delay: 1, wt: 0, stall: 1, tmo: 0};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_rd    = '0;
        #12;
        chk("rst_flags", {27'd0, bus.pcpi_valid, bus.out_valid, bus.timeout_err, bus.busy, bus.in_ready}, 32'd1);
        chk("rst_insn", bus.pcpi_insn, 32'd0);
        chk("rst_rs2",  bus.pcpi_rs2,  32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 6; n++) begin
            load_txn(vecs[n], 3*NSEG);
            respond(vecs[n]);
            tick();
        end

        // Reset after 10 segments: partial operands must be discarded.
        load_txn(vecs[5], 10);
        rst_n = 1'b0;
        #1;
        chk("rst_load_insn", bus.pcpi_insn, 32'd0);
        chk("rst_load_busy", {30'd0, bus.busy, bus.in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        load_txn(vecs[1], 3*NSEG);
        respond(vecs[1]);
        tick();

        // Reset while the request is outstanding.
        load_txn(vecs[2], 3*NSEG);
        tick();
        chk("issue_pv", {31'd0, bus.pcpi_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_issue_pv", {31'd0, bus.pcpi_valid}, 32'd0);
        chk("rst_issue_rs1", bus.pcpi_rs1, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        load_txn(vecs[0], 3*NSEG);
        respond(vecs[0]);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
